// File: rtl/mem_read_unit.sv
// Single-outstanding memory read unit: accept, strobe, wait with timeout,
// then hold the response until the consumer takes it.
module mem_read_unit #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // mem_done takes priority over a timeout in the same cycle
                if (mem_done) begin
                    data_d  = mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE) && rst;
    assign mem_en    = (state_q == ISSUE);
    assign mem_addr  = addr_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_read_unit.sv
// Bench for mem_read_unit: directed and randomized transactions checked
// against a transaction-level model of the read protocol.
module tb_mem_read_unit;

    localparam int W  = 16;
    localparam int AW = 16;
    localparam int TO = 15;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic          mem_busy;
    logic          mem_done;
    logic [W-1:0]  mem_rdata;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          rsp_ready;

    int n_tests = 0;
    int n_fail  = 0;

    mem_read_unit #(.WIDTH(W), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, ".rsp_err"},   32'(rsp_err),   0);
        chk({tag, ".mem_en"},    32'(mem_en),    0);
        chk({tag, ".req_ready"}, 32'(req_ready), 0);
        chk({tag, ".rsp_data"},  32'(rsp_data),  0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  0);
    endtask

    // Transaction model: memory stalls busy_n cycles, then answers in WAIT
    // cycle done_at (1-based); done_at > TO means it never answers.
    task automatic run_txn(input logic [AW-1:0] addr, input int busy_n,
                           input int done_at, input logic [W-1:0] rdata,
                           input int bp_n);
        int          wait_n;
        logic        exp_err;
        logic [W-1:0] exp_data;
        wait_n   = (done_at < TO) ? done_at : TO;
        exp_err  = (done_at > TO);
        exp_data = exp_err ? '0 : rdata;

        chk("idle.req_ready", 32'(req_ready), 1);
        chk("idle.rsp_valid", 32'(rsp_valid), 0);
        req_valid = 1'b1;
        req_addr  = addr;
        mem_done  = 1'($urandom);
        @(negedge clk);

        // Requests outside IDLE must be ignored, so keep poking req_valid.
        for (int i = 0; i <= busy_n; i++) begin
            req_valid = 1'($urandom);
            req_addr  = AW'($urandom);
            chk("issue.mem_en",   32'(mem_en),   1);
            chk("issue.mem_addr", 32'(mem_addr), 32'(addr));
            chk("issue.req_ready", 32'(req_ready), 0);
            mem_busy = (i < busy_n);
            mem_done = 1'($urandom);
            @(negedge clk);
        end
        mem_busy = 1'b0;

        for (int w = 1; w <= wait_n; w++) begin
            chk("wait.mem_en",    32'(mem_en),    0);
            chk("wait.rsp_valid", 32'(rsp_valid), 0);
            mem_done  = (w == done_at);
            mem_rdata = (w == done_at) ? rdata : W'($urandom);
            @(negedge clk);
        end
        mem_done = 1'b0;

        for (int k = 0; k <= bp_n; k++) begin
            chk("resp.rsp_valid", 32'(rsp_valid), 1);
            chk("resp.rsp_data",  32'(rsp_data),  32'(exp_data));
            chk("resp.rsp_err",   32'(rsp_err),   32'(exp_err));
            chk("resp.req_ready", 32'(req_ready), 0);
            chk("resp.mem_en",    32'(mem_en),    0);
            rsp_ready = (k == bp_n);
            req_valid = 1'b1;
            mem_done  = 1'($urandom);
            mem_rdata = W'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        mem_done  = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'h1111;
        mem_busy  = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 16'hDEAD;
        rsp_ready = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        chk_reset_outputs("por_hold");
        req_valid = 1'b0;
        mem_done  = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rel.req_ready", 32'(req_ready), 1);
        @(negedge clk);

        run_txn(16'h0040, 0, 1, 16'hBEEF, 0);
        run_txn(16'h0A5A, 4, 2, 16'hC0DE, 0);
        run_txn(16'h0100, 0, 100, 16'hFFFF, 0);
        run_txn(16'h0200, 1, TO, 16'h1234, 0);
        run_txn(16'h0300, 0, 3, 16'h5555, 6);
        run_txn(16'h0301, 2, TO + 1, 16'hAAAA, 2);

        // Reset while waiting for memory: request abandoned.
        req_valid = 1'b1;
        req_addr  = 16'h7777;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst.wait", 32'(mem_en), 0);
        rst       = 1'b0;
        req_valid = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        chk_reset_outputs("mid_rst_hold");
        req_valid = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 16'h9999;
        rst       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray.rsp_valid", 32'(rsp_valid), 0);
            chk("stray.req_ready", 32'(req_ready), 1);
        end
        mem_done = 1'b0;
        run_txn(16'h0ABC, 1, 4, 16'h4321, 1);

        for (int t = 0; t < 30; t++) begin
            run_txn(AW'($urandom), $urandom_range(0, 4),
                    $urandom_range(1, TO + 4), W'($urandom),
                    $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
